flow_fifo_bank: RTL
===================

# flow_fifo_bank

Parametrised per-flow FIFO bank. It is the next generation of the scheduler's per-flow element store. Each flow has a circular buffer with its own head, tail and occupancy counter, and the bank adds per-flow flush, an occupancy readout and a non-empty bitmap for the downstream PIFO scheduler. It sits between flow ingress and the scheduler, and accepts reinserts of popped elements in the same cycle as the pop.

## Interface
Parameters:
- NUM_FLOWS, 16, number of flows.
- DEPTH, 10, entries per flow; any value ≥2, not restricted to a power of two.
- DATA_WIDTH, 8, element (priority) width.
- IDX_WIDTH, $clog2(NUM_FLOWS+1), flow id width (derived).
- CNT_WIDTH, $clog2(DEPTH+1), occupancy width (derived).

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- i__push_valid  in  1  push request.
- i__push_flow_id  in  IDX_WIDTH  push target flow.
- i__push_data  in  DATA_WIDTH  push element.
- o__push_ready  out  1  push will be accepted this cycle.
- i__pop  in  1  pop request.
- i__pop_flow_id  in  IDX_WIDTH  pop, reinsert and count target flow.
- o__pop_valid  out  1  target flow non-empty and pop-eligible.
- o__pop_data  out  DATA_WIDTH  head element of the target flow.
- o__pop_count  out  CNT_WIDTH  occupancy of the target flow.
- i__reinsert_valid  in  1  append element to the tail of the popped flow.
- i__reinsert_data  in  DATA_WIDTH  reinserted element.
- i__flush_valid  in  1  empty a flow.
- i__flush_flow_id  in  IDX_WIDTH  flow to flush.
- o__flow_not_empty  out  NUM_FLOWS  per-flow count≠0 bitmap (registered state).

## Operation
- Per flow:
  - head and tail pointers, $clog2(DEPTH) bits, wrap from DEPTH-1 to 0.
  - count, 0..DEPTH.
- Storage is NUM_FLOWS×DEPTH flops, no reset; contents are don't-care when count=0.
- Push acceptance:
  - Accept = i__push_valid & o__push_ready.
  - o__push_ready = valid id & count[id]<DEPTH & !(i__reinsert_valid & id==i__pop_flow_id) & !(i__flush_valid & id==i__flush_flow_id).
  - Reinsert and flush take priority over push.
  - Full is judged on registered count. A pop in the same cycle does not free a slot for a push.
- Pop acceptance:
  - Accept = i__pop & o__pop_valid.
  - o__pop_valid = valid id & count≠0 & !(i__flush_valid & i__flush_flow_id==i__pop_flow_id).
  - o__pop_data = mem[id][head] combinationally; it is 0 when o__pop_valid=0.
- Reinsert:
  - Legal only with an accepted pop.
  - Writes at the tail of i__pop_flow_id; head and tail both advance, count is unchanged.
  - It can never overflow.
  - A reinsert without an accepted pop is ignored.
- Same-flow push and pop (no reinsert): both take effect, count unchanged.
- Flush:
  - head=tail=count=0 on the next edge.
  - Overrides any push, pop or reinsert to the same flow.
- Flow id ≥ NUM_FLOWS: o__push_ready=0, o__pop_valid=0, o__pop_count=0, flush ignored.
- Count update per flow: +1 on push accept, -1 on pop accept without reinsert. No saturation logic is needed, because the acceptance rules guarantee 0..DEPTH.

## Timing
- Reset value of every register and output: all pointers and counts 0, o__flow_not_empty=0, o__pop_valid=0, o__pop_data=0, o__pop_count=0, o__push_ready=1 for a valid id when no reinsert/flush collision.
- Reset is asynchronous mid-operation: all flows are emptied immediately and in-flight handshakes are lost.
- Push latency: data pushed at edge N is poppable (and reflected in o__flow_not_empty and o__pop_count) from cycle N+1.
- Pop and reinsert: combinational output, state updates at the next edge; zero-cycle read latency.
- There is no FIFO bypass: a push to an empty flow is never visible in the same cycle.

## Configuration
- FLOW_FIFO_BANK_ERR_EN defined: adds o__err_overflow and o__err_underflow (out, 1 bit each), sticky and cleared only by reset.
  - Overflow sets on i__push_valid to a valid flow whose count=DEPTH.
  - Underflow sets on i__pop with o__pop_valid=0, or on i__reinsert_valid without an accepted pop.
  - Flags are set one cycle after the event.
- Undefined: the ports do not exist and illegal requests are silently ignored as above.

## Structure
- Package flow_fifo_bank_pkg:
  - ptr_inc wrap function (parametrised by DEPTH via argument).
  - Per-flow control struct typedef: head, tail, count.
- Sub-module flow_fifo_ctrl: one instance per flow, generated NUM_FLOWS times.
  - Inputs: push/pop/reinsert/flush strobes.
  - Outputs: head, tail, count, not_empty.
- Storage and the id-indexed muxes live in the top.

## Test plan
- Reset, push 0x11 then 0x22 to flow 3, pop flow 3 twice: 0x11 then 0x22; o__flow_not_empty[3] is 1 after the first push and 0 after the second pop.
- Push 10 elements to flow 5 (DEPTH=10): o__push_ready=0 with o__pop_count=10; an 11th push is dropped. With ERR_EN, o__err_overflow=1 the next cycle.
- Pop 0xAA from flow 2 with reinsert 0xBB: count unchanged, and 0xBB comes out after the remaining elements.
- Same cycle: push flow 7 plus pop/reinsert flow 7. o__push_ready=0 and only the reinsert is stored. Wrap-around is checked by 25 push/pop cycles on a single flow.
- Flush flow 1 while pushing to flow 1 and popping flow 1: flow 1 is empty next cycle, the push is not accepted and the pop is not valid; other flows are unaffected.
- Assert reset mid-stream with 4 flows populated: all counts are 0 and o__flow_not_empty=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/flow_fifo_bank_pkg.sv
// Shared types and helpers for the per-flow FIFO bank.
// ptr_inc: circular pointer increment for any depth >= 2 (not only powers of two).
// flow_ctrl_t: per-flow head/tail/count snapshot, fields sized for the largest supported depth.
package flow_fifo_bank_pkg;

  localparam int CTRL_FIELD_W = 16;

  typedef struct packed {
    logic [CTRL_FIELD_W-1:0] head;
    logic [CTRL_FIELD_W-1:0] tail;
    logic [CTRL_FIELD_W-1:0] count;
  } flow_ctrl_t;

  // Wraps from depth-1 back to 0.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/flow_fifo_bank_if.sv
// Handshake bundle between flow ingress / scheduler and flow_fifo_bank.
// master: drives requests (i__*) and observes status (o__*); slave: the bank.
// Optional sticky error outputs exist only when FLOW_FIFO_BANK_ERR_EN is defined.
interface flow_fifo_bank_if #(
  parameter int NUM_FLOWS  = 16,
  parameter int DEPTH      = 10,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = $clog2(NUM_FLOWS + 1),
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
);
  logic                  i__push_valid;
  logic [IDX_WIDTH-1:0]  i__push_flow_id;
  logic [DATA_WIDTH-1:0] i__push_data;
  logic                  o__push_ready;
  logic                  i__pop;
  logic [IDX_WIDTH-1:0]  i__pop_flow_id;
  logic                  o__pop_valid;
  logic [DATA_WIDTH-1:0] o__pop_data;
  logic [CNT_WIDTH-1:0]  o__pop_count;
  logic                  i__reinsert_valid;
  logic [DATA_WIDTH-1:0] i__reinsert_data;
  logic                  i__flush_valid;
  logic [IDX_WIDTH-1:0]  i__flush_flow_id;
  logic [NUM_FLOWS-1:0]  o__flow_not_empty;
`ifdef FLOW_FIFO_BANK_ERR_EN
  logic                  o__err_overflow;
  logic                  o__err_underflow;
`endif

  modport master (
    output i__push_valid, i__push_flow_id, i__push_data,
    output i__pop, i__pop_flow_id,
    output i__reinsert_valid, i__reinsert_data,
    output i__flush_valid, i__flush_flow_id,
`ifdef FLOW_FIFO_BANK_ERR_EN
    input  o__err_overflow, o__err_underflow,
`endif
    input  o__push_ready, o__pop_valid, o__pop_data, o__pop_count, o__flow_not_empty
  );

  modport slave (
    input  i__push_valid, i__push_flow_id, i__push_data,
    input  i__pop, i__pop_flow_id,
    input  i__reinsert_valid, i__reinsert_data,
    input  i__flush_valid, i__flush_flow_id,
`ifdef FLOW_FIFO_BANK_ERR_EN
    output o__err_overflow, o__err_underflow,
`endif
    output o__push_ready, o__pop_valid, o__pop_data, o__pop_count, o__flow_not_empty
  );
endinterface

// File: rtl/flow_fifo_ctrl.sv
// Head/tail/count bookkeeping for one flow's circular buffer; strobes are pre-qualified by the bank.
// Ports: push/pop/reinsert/flush strobes in; head, tail, count, not_empty out.
// All outputs come straight from registers; flush wins over every other strobe.
module flow_fifo_ctrl
  import flow_fifo_bank_pkg::*;
#(
  parameter int DEPTH = 10,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             reinsert,
  input  logic             flush,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [CNT_W-1:0] count,
  output logic             not_empty
);

  flow_ctrl_t st, st_nxt;

  always_comb begin
    st_nxt = st;
    if (flush) begin
      st_nxt = '0;
    end else begin
      if (pop)
        st_nxt.head = CTRL_FIELD_W'(ptr_inc(32'(st.head), DEPTH));
      // push and reinsert never coincide on one flow: a reinsert blocks the push.
      if (push | reinsert)
        st_nxt.tail = CTRL_FIELD_W'(ptr_inc(32'(st.tail), DEPTH));
      // A reinserted pop is occupancy-neutral; push+pop on the same flow cancels.
      case ({push, pop & ~reinsert})
        2'b10:   st_nxt.count = st.count + 1'b1;
        2'b01:   st_nxt.count = st.count - 1'b1;
        default: st_nxt.count = st.count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= '0;
    else        st <= st_nxt;
  end

  assign head      = st.head[PTR_W-1:0];
  assign tail      = st.tail[PTR_W-1:0];
  assign count     = st.count[CNT_W-1:0];
  assign not_empty = (st.count != '0);

endmodule

// File: rtl/flow_fifo_bank.sv
// Per-flow FIFO bank: NUM_FLOWS circular buffers of DEPTH entries with push, pop(+reinsert), flush.
// Ports: clk, reset (async active-low), bus (flow_fifo_bank_if.slave); pop data/count are combinational.
// Backpressure via o__push_ready (full on registered count); optional errors under FLOW_FIFO_BANK_ERR_EN.
module flow_fifo_bank
  import flow_fifo_bank_pkg::*;
#(
  parameter int NUM_FLOWS  = 16,
  parameter int DEPTH      = 10,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = $clog2(NUM_FLOWS + 1),
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic reset,
  flow_fifo_bank_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]     head_a [NUM_FLOWS];
  logic [PTR_W-1:0]     tail_a [NUM_FLOWS];
  logic [CNT_WIDTH-1:0] cnt_a  [NUM_FLOWS];
  logic [NUM_FLOWS-1:0] push_acc, pop_acc, reins_acc, flush_hit, ne;

  // Storage is deliberately unreset; contents are meaningless while count is 0.
  logic [DATA_WIDTH-1:0] mem [NUM_FLOWS][DEPTH];

  logic                  push_id_ok, pop_id_ok;
  logic [CNT_WIDTH-1:0]  push_cnt, pop_cnt;
  logic [DATA_WIDTH-1:0] head_dat;
  logic                  push_fire, pop_fire;

  assign push_id_ok = bus.i__push_flow_id < IDX_WIDTH'(NUM_FLOWS);
  assign pop_id_ok  = bus.i__pop_flow_id  < IDX_WIDTH'(NUM_FLOWS);

  // Id-indexed read muxes; an out-of-range id matches no flow and reads as 0.
  always_comb begin
    push_cnt = '0;
    pop_cnt  = '0;
    head_dat = '0;
    for (int f = 0; f < NUM_FLOWS; f++) begin
      if (bus.i__push_flow_id == IDX_WIDTH'(f)) push_cnt = cnt_a[f];
      if (bus.i__pop_flow_id == IDX_WIDTH'(f)) begin
        pop_cnt  = cnt_a[f];
        head_dat = mem[f][head_a[f]];
      end
    end
  end

  assign bus.o__push_ready = push_id_ok && (push_cnt < CNT_WIDTH'(DEPTH))
                           && !(bus.i__reinsert_valid && bus.i__push_flow_id == bus.i__pop_flow_id)
                           && !(bus.i__flush_valid && bus.i__push_flow_id == bus.i__flush_flow_id);
  assign bus.o__pop_valid  = pop_id_ok && (pop_cnt != '0)
                           && !(bus.i__flush_valid && bus.i__flush_flow_id == bus.i__pop_flow_id);
  assign bus.o__pop_data   = bus.o__pop_valid ? head_dat : '0;
  assign bus.o__pop_count  = pop_cnt;
  assign bus.o__flow_not_empty = ne;

  assign push_fire = bus.i__push_valid & bus.o__push_ready;
  assign pop_fire  = bus.i__pop & bus.o__pop_valid;

  always_comb begin
    for (int f = 0; f < NUM_FLOWS; f++) begin
      push_acc[f]  = push_fire && (bus.i__push_flow_id == IDX_WIDTH'(f));
      pop_acc[f]   = pop_fire && (bus.i__pop_flow_id == IDX_WIDTH'(f));
      reins_acc[f] = pop_acc[f] && bus.i__reinsert_valid;
      flush_hit[f] = bus.i__flush_valid && (bus.i__flush_flow_id == IDX_WIDTH'(f));
    end
  end

  for (genvar g = 0; g < NUM_FLOWS; g++) begin : g_flow
    flow_fifo_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_WIDTH)) u_ctrl (
      .clk       (clk),
      .reset     (reset),
      .push      (push_acc[g]),
      .pop       (pop_acc[g]),
      .reinsert  (reins_acc[g]),
      .flush     (flush_hit[g]),
      .head      (head_a[g]),
      .tail      (tail_a[g]),
      .count     (cnt_a[g]),
      .not_empty (ne[g])
    );
  end

  // Two write ports (push, reinsert); they can only target the same flow when push is blocked.
  always_ff @(posedge clk) begin
    for (int f = 0; f < NUM_FLOWS; f++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (reins_acc[f] && tail_a[f] == PTR_W'(e))
          mem[f][e] <= bus.i__reinsert_data;
        else if (push_acc[f] && tail_a[f] == PTR_W'(e))
          mem[f][e] <= bus.i__push_data;
      end
    end
  end

`ifdef FLOW_FIFO_BANK_ERR_EN
  logic err_ovf, err_udf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (bus.i__push_valid && push_id_ok && push_cnt == CNT_WIDTH'(DEPTH))
        err_ovf <= 1'b1;
      if ((bus.i__pop && !bus.o__pop_valid) || (bus.i__reinsert_valid && !pop_fire))
        err_udf <= 1'b1;
    end
  end

  assign bus.o__err_overflow  = err_ovf;
  assign bus.o__err_underflow = err_udf;
`endif

endmodule
